inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port flush, input, 1, discard all queued entries (exception/mispredict redirect).
REQ-004 SHALL have ports push_valid (in, 1) and push_ready (out, 1), the IF-side handshake.
REQ-005 SHALL have push-payload inputs is_branch_taken_in (1), pht_index_in (`GHR_BUS), pc_in (`ADDR_BUS) and inst_in (`INST_BUS).
REQ-006 SHALL have ports pop_valid (out, 1) and pop_ready (in, 1), the ID-side handshake.
REQ-007 SHALL have head-entry outputs is_branch_taken_out (1), pht_index_out (`GHR_BUS), pc_out (`ADDR_BUS) and inst_out (`INST_BUS).
REQ-008 SHALL have port is_next_delayslot, input, 1, ID's decode of the instruction currently at the head.
REQ-009 SHALL have port is_current_delayslot, output, 1, marking that the head instruction sits in a delay slot.

Function
REQ-010 SHALL be a 4-entry circular FIFO with 2-bit read and write pointers and a 3-bit count (0..4).
REQ-011 SHALL treat push as occurring when push_valid && push_ready; push_ready = (count != 4).
REQ-012 SHALL treat pop as occurring when pop_valid && pop_ready; pop_valid = (count != 0).
REQ-013 SHALL reject push when full, even with a pop in the same cycle; push_ready does not depend on pop_ready.
REQ-014 SHALL, on simultaneous push and pop with 0 < count < 4, leave count unchanged and advance both pointers.
REQ-015 SHALL wrap pointers from 3 to 0 naturally (modulo 4).
REQ-016 SHALL take payload outputs combinationally from the entry at the read pointer, and drive all-zero payload when count == 0.
REQ-017 SHALL have push-to-pop latency of 1 cycle: an entry written at edge N is poppable in cycle N+1.
REQ-018 SHALL set a 1-bit delay-slot flag at the edge of a pop where is_next_delayslot = 1.
REQ-019 SHALL clear the delay-slot flag at the edge of a pop where is_next_delayslot = 0, and hold the flag when no pop occurs.
REQ-020 SHALL drive is_current_delayslot = flag && pop_valid.
REQ-021 SHALL, on flush, zero the pointers, count and delay-slot flag at the next edge, giving pop_valid = 0 and push_ready = 1 in the following cycle.
REQ-022 SHALL give flush priority over push and pop in the same cycle, so neither takes effect.

Reset
REQ-023 SHALL, while rst = 1, clear pointers, count and delay-slot flag at the edge; rst has priority over flush, push and pop.
REQ-024 SHALL have these outputs after reset: push_ready = 1, pop_valid = 0, all payload outputs 0, is_current_delayslot = 0.
REQ-025 SHALL NOT reset storage array contents; they are unobservable while count == 0.
REQ-026 SHALL, when reset is asserted mid-stream, discard every entry regardless of handshake state.

Configuration
REQ-027 SHALL, with macro INST_QUEUE_BYPASS_EN defined, bypass when count == 0 and push_valid = 1: pop_valid = 1 and the payload comes directly from the push inputs in the same cycle.
REQ-028 SHALL, in bypass with pop_ready = 1, consume the entry without writing it, leaving count at 0.
REQ-029 SHALL, in bypass with pop_ready = 0, write the entry normally.
REQ-030 SHALL apply no bypass during flush; flush still suppresses all effects.
REQ-031 SHALL, with INST_QUEUE_BYPASS_EN undefined, give empty-queue latency of exactly 1 cycle per REQ-017.

Verification
REQ-032 SHALL cover reset: push 2 entries, assert rst for 1 cycle -> pop_valid = 0, pc_out = 0, push_ready = 1.
REQ-033 SHALL cover fill/full: push pc 0x100, 0x104, 0x108, 0x10C with pop_ready = 0 -> push_ready = 0 after the 4th push; a 5th push (0x110) is rejected; pop order is 0x100..0x10C.
REQ-034 SHALL cover wrap: push 6 entries while popping 1 per cycle, with push and pop in the same cycle, so pointers wrap -> pops return push order and count never exceeds 2.
REQ-035 SHALL cover delay slot: pop a branch with is_next_delayslot = 1 -> the next head shows is_current_delayslot = 1; after it pops with is_next_delayslot = 0 -> 0.
REQ-036 SHALL cover flush: flush concurrent with push of 0x200 and pop, count 3 -> next cycle count 0, 0x200 absent, flag cleared.
REQ-037 SHALL cover bypass: with INST_QUEUE_BYPASS_EN and the queue empty, push 0x300 with pop_ready = 1 -> pc_out = 0x300 and pop_valid = 1 in the same cycle, count stays 0. Without the macro -> pop_valid = 1 in the next cycle.

Source files
------------

// File: rtl/inst_queue.sv
// 4-entry instruction queue between IF and ID, carrying the branch prediction info and a delay-slot
// flag for the head. Define INST_QUEUE_BYPASS_EN to let a push into an empty queue reach ID in the same cycle.

`ifndef GHR_BUS
`define GHR_BUS 7:0
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef INST_BUS
`define INST_BUS 31:0
`endif

module inst_queue (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push_valid,
    output logic            push_ready,
    input  logic            is_branch_taken_in,
    input  logic [`GHR_BUS]  pht_index_in,
    input  logic [`ADDR_BUS] pc_in,
    input  logic [`INST_BUS] inst_in,
    output logic            pop_valid,
    input  logic            pop_ready,
    output logic            is_branch_taken_out,
    output logic [`GHR_BUS]  pht_index_out,
    output logic [`ADDR_BUS] pc_out,
    output logic [`INST_BUS] inst_out,
    input  logic            is_next_delayslot,
    output logic            is_current_delayslot
);

    typedef struct packed {
        logic            br;
        logic [`GHR_BUS]  pht;
        logic [`ADDR_BUS] pc;
        logic [`INST_BUS] inst;
    } entry_t;

    entry_t [3:0] mem_q, mem_d;
    logic   [1:0] rd_ptr_q, rd_ptr_d;
    logic   [1:0] wr_ptr_q, wr_ptr_d;
    logic   [2:0] count_q, count_d;
    logic         ds_q, ds_d;

    entry_t push_entry;
    entry_t head;
    logic   empty;
    logic   full;
    logic   bypass;
    logic   bypass_consume;
    logic   do_push;
    logic   do_pop;
    logic   wr_en;
    logic   rd_en;

    always_comb begin
        push_entry = '{br: is_branch_taken_in, pht: pht_index_in, pc: pc_in, inst: inst_in};
        empty      = (count_q == 3'd0);
        full       = (count_q == 3'd4);
`ifdef INST_QUEUE_BYPASS_EN
        bypass     = empty && push_valid && !flush;
`else
        bypass     = 1'b0;
`endif
        push_ready = !full;
        pop_valid  = !empty || bypass;
        if (bypass) begin
            head = push_entry;
        end else if (empty) begin
            head = '0;
        end else begin
            head = mem_q[rd_ptr_q];
        end
        do_push        = push_valid && push_ready;
        do_pop         = pop_valid && pop_ready;
        // A bypassed entry consumed the same cycle never touches storage.
        bypass_consume = bypass && pop_ready;
        wr_en          = do_push && !bypass_consume;
        rd_en          = do_pop && !bypass_consume;
    end

    always_comb begin
        is_branch_taken_out  = head.br;
        pht_index_out        = head.pht;
        pc_out               = head.pc;
        inst_out             = head.inst;
        is_current_delayslot = ds_q && pop_valid;
    end

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ds_d     = ds_q;
        if (flush) begin
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
            count_d  = 3'd0;
            ds_d     = 1'b0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + 2'd1;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            if (wr_en && !rd_en) begin
                count_d = count_q + 3'd1;
            end else if (rd_en && !wr_en) begin
                count_d = count_q - 3'd1;
            end
            if (do_pop) begin
                ds_d = is_next_delayslot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ds_q     <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ds_q     <= ds_d;
        end
    end

    // Storage is not reset; contents are unreachable while the queue is empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: a table of per-cycle vectors plus hand-written reset and bypass
// sequences. Expectations adapt to INST_QUEUE_BYPASS_EN.

`ifndef GHR_BUS
`define GHR_BUS 7:0
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef INST_BUS
`define INST_BUS 31:0
`endif

module tb_inst_queue;

`ifdef INST_QUEUE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            push_valid;
    logic            push_ready;
    logic            is_branch_taken_in;
    logic [`GHR_BUS]  pht_index_in;
    logic [`ADDR_BUS] pc_in;
    logic [`INST_BUS] inst_in;
    logic            pop_valid;
    logic            pop_ready;
    logic            is_branch_taken_out;
    logic [`GHR_BUS]  pht_index_out;
    logic [`ADDR_BUS] pc_out;
    logic [`INST_BUS] inst_out;
    logic            is_next_delayslot;
    logic            is_current_delayslot;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_queue dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .push_valid          (push_valid),
        .push_ready          (push_ready),
        .is_branch_taken_in  (is_branch_taken_in),
        .pht_index_in        (pht_index_in),
        .pc_in               (pc_in),
        .inst_in             (inst_in),
        .pop_valid           (pop_valid),
        .pop_ready           (pop_ready),
        .is_branch_taken_out (is_branch_taken_out),
        .pht_index_out       (pht_index_out),
        .pc_out              (pc_out),
        .inst_out            (inst_out),
        .is_next_delayslot   (is_next_delayslot),
        .is_current_delayslot(is_current_delayslot)
    );

    // Side payload is derived from pc so a wrong entry or a torn read shows up.
    function automatic logic [`GHR_BUS] pht_of(input logic [`ADDR_BUS] pc);
        logic [31:0] p = 32'(pc);
        return (pc == 0) ? '0 : p[9:2];
    endfunction
    function automatic logic [`INST_BUS] inst_of(input logic [`ADDR_BUS] pc);
        logic [31:0] p = 32'(pc);
        return (pc == 0) ? '0 : {p[15:0], ~p[15:0]};
    endfunction
    function automatic logic br_of(input logic [`ADDR_BUS] pc);
        logic [31:0] p = 32'(pc);
        return p[2];
    endfunction

    typedef struct {
        logic        flush;
        logic        push;
        logic [31:0] pc;
        logic        pop;
        logic        nds;
        logic        e_pr;
        logic        e_pv;
        logic [31:0] e_pc;
        logic        e_cds;
    } vec_t;

    vec_t vecs[35];

    function automatic vec_t mk(input logic fl, input logic pu, input logic [31:0] pc,
                                input logic po, input logic nds, input logic e_pr,
                                input logic e_pv, input logic [31:0] e_pc, input logic e_cds);
        vec_t v;
        v.flush = fl; v.push = pu; v.pc = pc; v.pop = po; v.nds = nds;
        v.e_pr = e_pr; v.e_pv = e_pv; v.e_pc = e_pc; v.e_cds = e_cds;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic pu, input logic [31:0] pc, input logic po,
                         input logic nds);
        flush              = fl;
        push_valid         = pu;
        pc_in              = pc;
        pht_index_in       = pht_of(pc);
        inst_in            = inst_of(pc);
        is_branch_taken_in = br_of(pc);
        pop_ready          = po;
        is_next_delayslot  = nds;
    endtask

    task automatic check_outputs(input string tag, input logic e_pr, input logic e_pv,
                                 input logic [31:0] e_pc, input logic e_cds);
        chk({tag, ".push_ready"}, 32'(push_ready), 32'(e_pr));
        chk({tag, ".pop_valid"}, 32'(pop_valid), 32'(e_pv));
        chk({tag, ".pc_out"}, 32'(pc_out), e_pc);
        chk({tag, ".pht_out"}, 32'(pht_index_out), 32'(pht_of(e_pc)));
        chk({tag, ".inst_out"}, 32'(inst_out), 32'(inst_of(e_pc)));
        chk({tag, ".br_out"}, 32'(is_branch_taken_out), 32'(br_of(e_pc)));
        chk({tag, ".cur_ds"}, 32'(is_current_delayslot), 32'(e_cds));
    endtask

    // Inputs change #1 after posedge, outputs are sampled on the negedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fill to full, reject a fifth push, drain in order.
        vecs[0]  = mk(0, 1, 32'h100, 0, 0, 1, Byp, Byp ? 32'h100 : 32'h0, 0);
        vecs[1]  = mk(0, 1, 32'h104, 0, 0, 1, 1, 32'h100, 0);
        vecs[2]  = mk(0, 1, 32'h108, 0, 0, 1, 1, 32'h100, 0);
        vecs[3]  = mk(0, 1, 32'h10C, 0, 0, 1, 1, 32'h100, 0);
        vecs[4]  = mk(0, 1, 32'h110, 0, 0, 0, 1, 32'h100, 0);
        vecs[5]  = mk(0, 0, 32'h0,   1, 0, 0, 1, 32'h100, 0);
        vecs[6]  = mk(0, 0, 32'h0,   1, 0, 1, 1, 32'h104, 0);
        vecs[7]  = mk(0, 0, 32'h0,   1, 0, 1, 1, 32'h108, 0);
        vecs[8]  = mk(0, 0, 32'h0,   1, 0, 1, 1, 32'h10C, 0);
        vecs[9]  = mk(0, 0, 32'h0,   0, 0, 1, 0, 32'h0,   0);
        // Streaming push+pop so both pointers wrap.
        vecs[10] = mk(0, 1, 32'h400, 0, 0, 1, Byp, Byp ? 32'h400 : 32'h0, 0);
        vecs[11] = mk(0, 1, 32'h404, 1, 0, 1, 1, 32'h400, 0);
        vecs[12] = mk(0, 1, 32'h408, 1, 0, 1, 1, 32'h404, 0);
        vecs[13] = mk(0, 1, 32'h40C, 1, 0, 1, 1, 32'h408, 0);
        vecs[14] = mk(0, 1, 32'h410, 1, 0, 1, 1, 32'h40C, 0);
        vecs[15] = mk(0, 1, 32'h414, 1, 0, 1, 1, 32'h410, 0);
        vecs[16] = mk(0, 0, 32'h0,   1, 0, 1, 1, 32'h414, 0);
        vecs[17] = mk(0, 0, 32'h0,   0, 0, 1, 0, 32'h0,   0);
        // Delay-slot flag set, held without pop, cleared by the next pop.
        vecs[18] = mk(0, 1, 32'h500, 0, 0, 1, Byp, Byp ? 32'h500 : 32'h0, 0);
        vecs[19] = mk(0, 1, 32'h504, 0, 0, 1, 1, 32'h500, 0);
        vecs[20] = mk(0, 1, 32'h508, 0, 0, 1, 1, 32'h500, 0);
        vecs[21] = mk(0, 0, 32'h0,   1, 1, 1, 1, 32'h500, 0);
        vecs[22] = mk(0, 0, 32'h0,   0, 0, 1, 1, 32'h504, 1);
        vecs[23] = mk(0, 0, 32'h0,   1, 0, 1, 1, 32'h504, 1);
        vecs[24] = mk(0, 0, 32'h0,   0, 0, 1, 1, 32'h508, 0);
        // Build count 3 with flag set, then flush alongside push 0x200 and pop.
        vecs[25] = mk(0, 1, 32'h50C, 0, 0, 1, 1, 32'h508, 0);
        vecs[26] = mk(0, 1, 32'h510, 0, 0, 1, 1, 32'h508, 0);
        vecs[27] = mk(0, 0, 32'h0,   1, 1, 1, 1, 32'h508, 0);
        vecs[28] = mk(0, 1, 32'h514, 0, 0, 1, 1, 32'h50C, 1);
        vecs[29] = mk(1, 1, 32'h200, 1, 0, 1, 1, 32'h50C, 1);
        vecs[30] = mk(0, 0, 32'h0,   0, 0, 1, 0, 32'h0,   0);
        vecs[31] = mk(0, 1, 32'h600, 0, 0, 1, Byp, Byp ? 32'h600 : 32'h0, 0);
        vecs[32] = mk(0, 0, 32'h0,   0, 0, 1, 1, 32'h600, 0);
        vecs[33] = mk(0, 0, 32'h0,   1, 0, 1, 1, 32'h600, 0);
        vecs[34] = mk(0, 0, 32'h0,   0, 0, 1, 0, 32'h0,   0);

        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_outputs("reset", 1, 0, 32'h0, 0);

        // Mid-stream reset discards queued entries.
        next_cycle();
        drive(0, 1, 32'h800, 0, 0);
        next_cycle();
        drive(0, 1, 32'h804, 0, 0);
        @(negedge clk);
        check_outputs("pre_rst", 1, 1, 32'h800, 0);
        next_cycle();
        rst = 1'b1;
        drive(0, 1, 32'h808, 1, 1);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0);
        @(negedge clk);
        check_outputs("mid_rst", 1, 0, 32'h0, 0);
        next_cycle();

        for (int i = 0; i < 35; i++) begin
            drive(vecs[i].flush, vecs[i].push, vecs[i].pc, vecs[i].pop, vecs[i].nds);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_pr, vecs[i].e_pv, vecs[i].e_pc,
                          vecs[i].e_cds);
            next_cycle();
        end

        // Empty queue, push with pop_ready: same-cycle with bypass, next cycle without.
        drive(0, 1, 32'h300, 1, 0);
        @(negedge clk);
        check_outputs("byp_same", 1, Byp, Byp ? 32'h300 : 32'h0, 0);
        next_cycle();
        drive(0, 0, 32'h0, 1, 0);
        @(negedge clk);
        check_outputs("byp_next", 1, !Byp, Byp ? 32'h0 : 32'h300, 0);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0);
        @(negedge clk);
        check_outputs("byp_drain", 1, 0, 32'h0, 0);
        next_cycle();

        // Flush into an empty queue suppresses bypass and the write.
        drive(1, 1, 32'h700, 1, 1);
        @(negedge clk);
        check_outputs("flush_empty", 1, 0, 32'h0, 0);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0);
        @(negedge clk);
        check_outputs("flush_after", 1, 0, 32'h0, 0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
